exec_ctrl: RTL and testbench
============================

# exec_ctrl

Execute-stage controller sharing one single-cycle ALU and one multi-cycle multiply/divide unit between instruction issue and writeback. Accepts one operation at a time on a valid/ready handshake and routes opcodes 0–5 to the ALU and opcodes 6–7 to multdiv. For multdiv operations it holds the operands stable, pulses the start strobe and waits for `md_resultRDY`. It returns every result, its destination tag and an exception flag through a registered valid/ready output slot.

## Interface
- `MD_TIMEOUT`, default 64: cycles waited in MD_WAIT before the watchdog aborts.
- `TAG_W`, default 5: width of the destination tag.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an issue request is present.
- `in_ready`  out  1  the controller accepts the request this cycle.
- `in_opcode`  in  5  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 mult, 7 div.
- `in_shamt`  in  5  shift amount.
- `in_A`, `in_B`  in  32 each  operands.
- `in_tag`  in  TAG_W  destination tag.
- `alu_opA`, `alu_opB`  out  32 each  ALU operands; combinational pass-through of `in_A`/`in_B`.
- `alu_opcode`, `alu_shamt`  out  5 each  ALU controls; combinational pass-through.
- `alu_result`  in  32  ALU result.
- `alu_overflow`  in  1  ALU signed overflow.
- `md_opA`, `md_opB`  out  32 each  registered multdiv operands.
- `md_mult`, `md_div`  out  1 each  one-cycle start strobes.
- `md_result`  in  32  multdiv result.
- `md_exception`  in  1  multdiv exception.
- `md_resultRDY`  in  1  multdiv result valid.
- `out_valid`  out  1  a result is held in the output slot.
- `out_ready`  in  1  the consumer takes the result.
- `out_result`  out  32  result.
- `out_tag`  out  TAG_W  destination tag of the result.
- `out_exception`  out  1  exception flag of the result.
- `busy`  out  1  a multdiv operation is in flight (state is not IDLE).

## Operation
- States: IDLE, MD_START, MD_WAIT.
- `in_ready` = (state == IDLE) && (!`out_valid` || `out_ready`).
- A request is accepted on a cycle where `in_valid` && `in_ready`.
- Opcodes 0–5, accepted in IDLE: `alu_result` is captured into the output slot. `out_exception` = `alu_overflow` for opcodes 0 and 1, and 0 for opcodes 2–5. State stays IDLE.
- Opcodes 8–31: the output slot is loaded with `out_result` = 0 and `out_exception` = 1. State stays IDLE.
- Opcodes 6–7: `in_A`/`in_B` are latched into `md_opA`/`md_opB` and the tag and opcode are latched internally. State goes to MD_START.
- MD_START: drives `md_mult` (opcode 6) or `md_div` (opcode 7) high for exactly this cycle, then goes to MD_WAIT. Any `md_resultRDY` in this cycle is ignored.
- MD_WAIT: on `md_resultRDY` = 1 the output slot is loaded with `md_result`, `out_exception` = `md_exception` and the latched tag; state goes to IDLE.
- `md_opA`/`md_opB` stay constant from MD_START until the controller returns to IDLE.
- Output slot: `out_valid` is set when the slot is loaded and cleared when `out_valid` && `out_ready` with no new load in the same cycle. Draining the slot and loading it in the same cycle is legal and leaves `out_valid` = 1 with the new data.
- The output slot is always empty when a multdiv operation completes, because a multdiv request is only accepted with the slot free or draining and no request is accepted while busy.
- `md_resultRDY` while in IDLE is ignored.

## Timing
- Reset values: state IDLE; `out_valid`, `out_exception`, `md_mult`, `md_div` = 0; `out_result`, `out_tag`, `md_opA`, `md_opB` = 0. With the output slot empty, `in_ready` = 1.
- ALU operation accepted at cycle N: `out_valid` = 1 at N+1.
- Multdiv operation accepted at cycle N: start strobe high at N+1; MD_WAIT from N+2. With `md_resultRDY` sampled high at cycle M, `out_valid` = 1 at M+1 and `in_ready` can be 1 at M+1.
- `in_ready` = 0 from N+1 until the cycle after `md_resultRDY` is sampled.
- Reset asserted mid-operation: all state returns to the reset values immediately; any later `md_resultRDY` is ignored.

## Configuration
- Macro `EXEC_CTRL_TIMEOUT_EN`.
- Defined: an 8-bit wait counter clears on entry to MD_WAIT and increments every MD_WAIT cycle. If it reaches `MD_TIMEOUT` with no `md_resultRDY`, the output slot is loaded with `out_result` = 0, `out_exception` = 1 and the latched tag, and state goes to IDLE. If `md_resultRDY` arrives on the same cycle the counter reaches `MD_TIMEOUT`, the result wins.
- Undefined: no counter; MD_WAIT waits indefinitely for `md_resultRDY`.

## Test plan
- Add 5 + 7, `out_ready` held 1 -> `out_valid` one cycle after accept, `out_result` = 12, `out_exception` = 0, tag echoed.
- Add 0x7FFFFFFF + 1 -> `out_result` = 0x80000000, `out_exception` = 1. Opcode 9 -> `out_result` = 0, `out_exception` = 1.
- Mult 6 × 7, `md_resultRDY` returned 17 cycles after the strobe -> exactly one `md_mult` pulse. `md_opA`/`md_opB` stable for the whole operation. `in_ready` = 0 while busy. `out_result` = 42 one cycle after RDY.
- `out_ready` = 0 for 3 cycles after a result -> `out_valid`/`out_result` held and `in_ready` = 0. Then back-to-back requests with `out_ready` = 1 -> one result per cycle.
- With `EXEC_CTRL_TIMEOUT_EN` and `MD_TIMEOUT` = 64, div with no RDY -> after 64 MD_WAIT cycles `out_exception` = 1 and `out_result` = 0. Without the macro -> controller still busy after 200 cycles.
- `reset_n` low during MD_WAIT, then a late `md_resultRDY` -> IDLE, `out_valid` = 0, no result produced.

Source files
------------

// File: rtl/exec_ctrl_if.sv
// exec_ctrl bus bundle: issue handshake, ALU and multdiv sideband, result slot.
// master = environment side (issuer, ALU, multdiv unit, consumer),
// slave  = the exec_ctrl controller.
interface exec_ctrl_if #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_opcode;
  logic [4:0]       in_shamt;
  logic [31:0]      in_A;
  logic [31:0]      in_B;
  logic [TAG_W-1:0] in_tag;

  logic [31:0]      alu_opA;
  logic [31:0]      alu_opB;
  logic [4:0]       alu_opcode;
  logic [4:0]       alu_shamt;
  logic [31:0]      alu_result;
  logic             alu_overflow;

  logic [31:0]      md_opA;
  logic [31:0]      md_opB;
  logic             md_mult;
  logic             md_div;
  logic [31:0]      md_result;
  logic             md_exception;
  logic             md_resultRDY;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_exception;
  logic             busy;

  modport master (
    output in_valid, in_opcode, in_shamt, in_A, in_B, in_tag,
           alu_result, alu_overflow,
           md_result, md_exception, md_resultRDY,
           out_ready,
    input  in_ready, alu_opA, alu_opB, alu_opcode, alu_shamt,
           md_opA, md_opB, md_mult, md_div,
           out_valid, out_result, out_tag, out_exception, busy
  );

  modport slave (
    input  in_valid, in_opcode, in_shamt, in_A, in_B, in_tag,
           alu_result, alu_overflow,
           md_result, md_exception, md_resultRDY,
           out_ready,
    output in_ready, alu_opA, alu_opB, alu_opcode, alu_shamt,
           md_opA, md_opB, md_mult, md_div,
           out_valid, out_result, out_tag, out_exception, busy
  );
endinterface

// File: rtl/exec_ctrl.sv
// exec_ctrl: execute-stage controller sharing a single-cycle ALU and a
// multi-cycle multiply/divide unit, with a registered result slot.
// Optional MD_WAIT watchdog enabled by defining EXEC_CTRL_TIMEOUT_EN.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_IDLE     | accepting requests; ALU/illegal ops complete here
// S_MD_START | one-cycle start strobe to multdiv, operands held
// S_MD_WAIT  | waiting for md_resultRDY (or watchdog expiry)
module exec_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int TAG_W      = 5
) (
  input logic        clock,
  input logic        reset_n,
  exec_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MD_START = 2'd1;
  localparam logic [1:0] S_MD_WAIT  = 2'd2;

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (MD_TIMEOUT < 1 || MD_TIMEOUT > 255) begin : g_bad_md_timeout
    $error("exec_ctrl: MD_TIMEOUT must be in 1..255");
  end

  logic [1:0]       state_q, state_d;
  logic [31:0]      md_opA_q, md_opA_d;
  logic [31:0]      md_opB_q, md_opB_d;
  logic [TAG_W-1:0] tag_lat_q, tag_lat_d;
  logic             is_div_q, is_div_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_exc_q, out_exc_d;
`ifdef EXEC_CTRL_TIMEOUT_EN
  logic [7:0]       wait_cnt_q, wait_cnt_d;
`endif

  logic             in_ready;
  logic             accept;
  logic             load;
  logic [31:0]      load_res;
  logic             load_exc;
  logic [TAG_W-1:0] load_tag;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Next-state, operand latch and slot-load selection.
  always_comb begin
    state_d  = state_q;
    md_opA_d = md_opA_q;
    md_opB_d = md_opB_q;
    tag_lat_d = tag_lat_q;
    is_div_d = is_div_q;
    load     = 1'b0;
    load_res = '0;
    load_exc = 1'b0;
    load_tag = bus.in_tag;
`ifdef EXEC_CTRL_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_opcode <= 5'd5) begin
            load     = 1'b1;
            load_res = bus.alu_result;
            load_exc = bus.alu_overflow && (bus.in_opcode <= 5'd1);
          end else if (bus.in_opcode <= 5'd7) begin
            md_opA_d  = bus.in_A;
            md_opB_d  = bus.in_B;
            tag_lat_d = bus.in_tag;
            is_div_d  = bus.in_opcode[0];
            state_d   = S_MD_START;
          end else begin
            load     = 1'b1;
            load_exc = 1'b1;
          end
        end
      end
      S_MD_START: begin
        // Any md_resultRDY here belongs to nothing we started; ignore it.
        state_d = S_MD_WAIT;
`ifdef EXEC_CTRL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      S_MD_WAIT: begin
        load_tag = tag_lat_q;
`ifdef EXEC_CTRL_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q + 8'd1;
`endif
        if (bus.md_resultRDY) begin
          load     = 1'b1;
          load_res = bus.md_result;
          load_exc = bus.md_exception;
          state_d  = S_IDLE;
        end
`ifdef EXEC_CTRL_TIMEOUT_EN
        else if (wait_cnt_q == 8'(MD_TIMEOUT - 1)) begin
          // This cycle is the MD_TIMEOUT-th wait cycle: abort with exception.
          load     = 1'b1;
          load_exc = 1'b1;
          state_d  = S_IDLE;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output slot: a load wins over a same-cycle drain.
  always_comb begin
    out_valid_d  = out_valid_q && !bus.out_ready;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_exc_d    = out_exc_q;
    if (load) begin
      out_valid_d  = 1'b1;
      out_result_d = load_res;
      out_tag_d    = load_tag;
      out_exc_d    = load_exc;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      md_opA_q     <= '0;
      md_opB_q     <= '0;
      tag_lat_q    <= '0;
      is_div_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_exc_q    <= 1'b0;
`ifdef EXEC_CTRL_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      md_opA_q     <= md_opA_d;
      md_opB_q     <= md_opB_d;
      tag_lat_q    <= tag_lat_d;
      is_div_q     <= is_div_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_exc_q    <= out_exc_d;
`ifdef EXEC_CTRL_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.alu_opA       = bus.in_A;
  assign bus.alu_opB       = bus.in_B;
  assign bus.alu_opcode    = bus.in_opcode;
  assign bus.alu_shamt     = bus.in_shamt;
  assign bus.md_opA        = md_opA_q;
  assign bus.md_opB        = md_opB_q;
  assign bus.md_mult       = (state_q == S_MD_START) && !is_div_q;
  assign bus.md_div        = (state_q == S_MD_START) && is_div_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_tag       = out_tag_q;
  assign bus.out_exception = out_exc_q;
  assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: vector table for ALU/illegal opcodes,
// scoreboard queue for results, hand sequences for multdiv, back-pressure,
// reset mid-operation and the MD_WAIT watchdog.
module tb_exec_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  exec_ctrl_if #(.TAG_W(5)) bus ();

  exec_ctrl #(.MD_TIMEOUT(64), .TAG_W(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        exc;
  } exp_t;

  vec_t vecs[11];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mult_cnt = 0;
  int   div_cnt = 0;

  // Reference ALU: ops 2..5 and illegal opcodes report overflow so the
  // controller's masking is exercised.
  always_comb begin
    logic [31:0] r;
    logic        v;
    r = 32'hDEAD_BEEF;
    v = 1'b1;
    case (bus.alu_opcode)
      5'd0: begin
        r = bus.alu_opA + bus.alu_opB;
        v = (bus.alu_opA[31] == bus.alu_opB[31]) && (r[31] != bus.alu_opA[31]);
      end
      5'd1: begin
        r = bus.alu_opA - bus.alu_opB;
        v = (bus.alu_opA[31] != bus.alu_opB[31]) && (r[31] != bus.alu_opA[31]);
      end
      5'd2: r = bus.alu_opA & bus.alu_opB;
      5'd3: r = bus.alu_opA | bus.alu_opB;
      5'd4: r = bus.alu_opA << bus.alu_shamt;
      5'd5: r = $unsigned($signed(bus.alu_opA) >>> bus.alu_shamt);
      default: ;
    endcase
    bus.alu_result   = r;
    bus.alu_overflow = v;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every transferred result must match the queue head.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got 0x%08h tag %0d, expected none", bus.out_result, bus.out_tag);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_result", bus.out_result, e.res);
        chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
        chk("out_exception", 32'(bus.out_exception), 32'(e.exc));
      end
    end
    if (bus.md_mult) mult_cnt++;
    if (bus.md_div) div_cnt++;
  end

  // Drive one request; push its expected result when acceptance is certain.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [4:0] tag, input bit push,
                       input logic [31:0] er, input logic ee, output int waited);
    exp_t e;
    waited = 0;
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_A      = a;
    bus.in_B      = b;
    bus.in_shamt  = sh;
    bus.in_tag    = tag;
    @(negedge clock);
    while (!bus.in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready got 0, expected 1 within 50 cycles");
    end else if (push) begin
      e.res = er;
      e.tag = tag;
      e.exc = ee;
      sb_q.push_back(e);
    end
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int bad;
    vecs[0]  = '{5'd0,  32'd5,          32'd7,          5'd0,  32'd12,         1'b0};
    vecs[1]  = '{5'd0,  32'h7FFF_FFFF,  32'd1,          5'd0,  32'h8000_0000,  1'b1};
    vecs[2]  = '{5'd1,  32'd10,         32'd3,          5'd0,  32'd7,          1'b0};
    vecs[3]  = '{5'd1,  32'h8000_0000,  32'd1,          5'd0,  32'h7FFF_FFFF,  1'b1};
    vecs[4]  = '{5'd2,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd0,  32'h00F0_00F0,  1'b0};
    vecs[5]  = '{5'd3,  32'h1200_0034,  32'h0000_5600,  5'd0,  32'h1200_5634,  1'b0};
    vecs[6]  = '{5'd4,  32'd1,          32'd0,          5'd31, 32'h8000_0000,  1'b0};
    vecs[7]  = '{5'd5,  32'h8000_0000,  32'd0,          5'd4,  32'hF800_0000,  1'b0};
    vecs[8]  = '{5'd9,  32'd1,          32'd2,          5'd0,  32'd0,          1'b1};
    vecs[9]  = '{5'd31, 32'd3,          32'd4,          5'd0,  32'd0,          1'b1};
    vecs[10] = '{5'd1,  32'd0,          32'd0,          5'd0,  32'd0,          1'b0};

    bus.in_valid = 1'b0;
    bus.in_opcode = '0;
    bus.in_A = '0;
    bus.in_B = '0;
    bus.in_shamt = '0;
    bus.in_tag = '0;
    bus.md_result = '0;
    bus.md_exception = 1'b0;
    bus.md_resultRDY = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_md_strobes", {30'd0, bus.md_mult, bus.md_div}, 32'd0);
    chk("rst_md_opA", bus.md_opA, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_tag_exc", {26'd0, bus.out_tag, bus.out_exception}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Vector table, back-to-back with the consumer always ready.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, 5'(i + 1), 1'b1,
            vecs[i].res, vecs[i].exc, w);
      chk("vec_out_valid_next_cycle", 32'(bus.out_valid), 32'd1);
      if (i > 0) chk("vec_b2b_no_stall", 32'(w), 32'd0);
    end
    @(posedge clock);
    #1;

    // Back-pressure: result held, no new accept, for 3 cycles.
    bus.out_ready = 1'b0;
    issue(5'd0, 32'd1, 32'd2, 5'd0, 5'd7, 1'b1, 32'd3, 1'b0, w);
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_result", bus.out_result, 32'd3);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Multiply: RDY in the strobe cycle is ignored; real RDY 17 cycles later.
    mult_cnt = 0;
    issue(5'd6, 32'd6, 32'd7, 5'd0, 5'd3, 1'b1, 32'd42, 1'b0, w);
    chk("mult_strobe", {30'd0, bus.md_mult, bus.md_div}, 32'd2);
    chk("mult_busy", 32'(bus.busy), 32'd1);
    chk("mult_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mult_opA", bus.md_opA, 32'd6);
    chk("mult_opB", bus.md_opB, 32'd7);
    bus.md_resultRDY = 1'b1;
    bus.md_result = 32'd99;
    @(posedge clock);
    #1;
    bus.md_resultRDY = 1'b0;
    chk("mult_strobe_off", 32'(bus.md_mult), 32'd0);
    bad = 0;
    for (int k = 2; k <= 17; k++) begin
      @(posedge clock);
      #1;
      if (bus.in_ready || !bus.busy || bus.out_valid || bus.md_opA != 32'd6 || bus.md_opB != 32'd7)
        bad++;
    end
    chk("mult_wait_stable", 32'(bad), 32'd0);
    bus.md_resultRDY = 1'b1;
    bus.md_result = 32'd42;
    @(posedge clock);
    #1;
    bus.md_resultRDY = 1'b0;
    chk("mult_done_valid", 32'(bus.out_valid), 32'd1);
    chk("mult_done_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mult_done_busy", 32'(bus.busy), 32'd0);
    chk("mult_pulse_count", 32'(mult_cnt), 32'd1);
    @(posedge clock);
    #1;

    // Reset during MD_WAIT, then a stale RDY must produce nothing.
    issue(5'd6, 32'd3, 32'd4, 5'd0, 5'd9, 1'b0, 32'd0, 1'b0, w);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_md_opA", bus.md_opA, 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    bus.md_resultRDY = 1'b1;
    bus.md_result = 32'd55;
    repeat (2) @(posedge clock);
    #1;
    bus.md_resultRDY = 1'b0;
    chk("late_rdy_out_valid", 32'(bus.out_valid), 32'd0);
    chk("late_rdy_busy", 32'(bus.busy), 32'd0);

    // Divide with no RDY: watchdog abort, or indefinite wait.
    div_cnt = 0;
`ifdef EXEC_CTRL_TIMEOUT_EN
    issue(5'd7, 32'd100, 32'd0, 5'd0, 5'd11, 1'b1, 32'd0, 1'b1, w);
`else
    issue(5'd7, 32'd100, 32'd0, 5'd0, 5'd11, 1'b0, 32'd0, 1'b0, w);
`endif
    chk("div_strobe", {30'd0, bus.md_mult, bus.md_div}, 32'd1);
`ifdef EXEC_CTRL_TIMEOUT_EN
    repeat (64) @(posedge clock);
    #1;
    chk("div_tmo_not_yet", 32'(bus.out_valid), 32'd0);
    chk("div_tmo_busy", 32'(bus.busy), 32'd1);
    @(posedge clock);
    #1;
    chk("div_tmo_valid", 32'(bus.out_valid), 32'd1);
    chk("div_tmo_idle", 32'(bus.busy), 32'd0);
`else
    repeat (200) @(posedge clock);
    #1;
    chk("div_hang_busy", 32'(bus.busy), 32'd1);
    chk("div_hang_in_ready", 32'(bus.in_ready), 32'd0);
    chk("div_hang_out_valid", 32'(bus.out_valid), 32'd0);
`endif
    chk("div_pulse_count", 32'(div_cnt), 32'd1);

    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
